// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, keymap and helpers for the keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] key_code_t;

  // Indexed col*4+row; c0 is the leftmost keypad column.
  localparam key_code_t KEYMAP [NUM_ROWS*NUM_COLS] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and key event outputs
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0] row;
  logic [3:0] col;
  key_code_t  key_code;
  logic       key_valid;
  logic       key_pressed;
  logic       multi_key;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_pressed,
    output multi_key
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_pressed,
    input  multi_key
  );
endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - commits a full-scan key state after N identical scans
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snapshot_i,
  input  logic        scan_done_i,
  output logic [15:0] committed_o
);

  localparam int              CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [15:0]   prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   committed_q, committed_d;

  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    if (scan_done_i) begin
      if (snapshot_i != prev_q) begin
        prev_d = snapshot_i;
        cnt_d  = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      if ((cnt_d == CNT_MAX) && (snapshot_i != committed_q)) begin
        committed_d = snapshot_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      committed_q <= '0;
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
    end
  end

  assign committed_o = committed_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and key events
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int            TW         = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic          slot_end, scan_done;
  logic [15:0]   committed, commit_prev_q;
  logic [4:0]    pop;
  key_code_t     key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_pressed_q, key_pressed_d;
  logic          multi_q, multi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  // Rows are sampled on the last cycle of each slot so the synchroniser has settled.
  always_comb begin
    slot_end  = (timer_q == TIMER_LAST);
    timer_d   = slot_end ? '0 : timer_q + TW'(1);
    col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = ~(4'b0001 << col_idx_d);
    snap_d    = snap_q;
    if (slot_end) begin
      snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
    end
    scan_done = slot_end && (col_idx_q == 2'd3);
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .snapshot_i  (snap_d),
    .scan_done_i (scan_done),
    .committed_o (committed)
  );

  // An event fires only on the zero-keys to exactly-one-key transition.
  always_comb begin
    pop           = popcount16(committed);
    key_pressed_d = |committed;
    multi_d       = (pop >= 5'd2);
    key_valid_d   = (commit_prev_q == '0) && (pop == 5'd1);
    key_code_d    = key_code_q;
    if (key_valid_d) begin
      for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
        if (committed[i]) begin
          key_code_d = KEYMAP[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q       <= '0;
      col_idx_q     <= '0;
      col_q         <= 4'b1110;
      snap_q        <= '0;
      commit_prev_q <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      col_idx_q     <= col_idx_d;
      col_q         <= col_d;
      snap_q        <= snap_d;
      commit_prev_q <= committed;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      multi_q       <= multi_d;
    end
  end

  assign kp.col         = col_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] held;
  int          n_cmp;
  int          n_err;
  int          n_pulse;
  logic [3:0]  last_code;
  int          base;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a held key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kp.row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!kp.col[c] && held[c*4+r]) kp.row[r] = 1'b0;
      end
    end
  end

  initial begin
    n_pulse   = 0;
    last_code = 4'h0;
  end

  always @(negedge clk) begin
    if (kp.key_valid) begin
      n_pulse   = n_pulse + 1;
      last_code = kp.key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    held  = '0;
    wait_cyc(3);
    rst = 1'b0;
    check("rst_col", kp.col, 4'b1110);
    check("rst_code", kp.key_code, 4'h0);
    check("rst_valid", kp.key_valid, 1'b0);
    check("rst_pressed", kp.key_pressed, 1'b0);
    check("rst_multi", kp.multi_key, 1'b0);
    wait_cyc(4); check("col_step1", kp.col, 4'b1101);
    wait_cyc(4); check("col_step2", kp.col, 4'b1011);
    wait_cyc(4); check("col_step3", kp.col, 4'b0111);
    wait_cyc(4); check("col_wrap", kp.col, 4'b1110);

    // Single press of "5" (r1,c1)
    base = n_pulse;
    held[5] = 1'b1;
    wait_cyc(70);
    check("k5_pulses", n_pulse - base, 1);
    check("k5_code", last_code, 4'h5);
    check("k5_pressed", kp.key_pressed, 1'b1);
    check("k5_multi", kp.multi_key, 1'b0);
    held = '0;
    wait_cyc(70);
    check("k5_released", kp.key_pressed, 1'b0);
    check("k5_no_rel_pulse", n_pulse - base, 1);

    // Bounce on "A" (r0,c3); a one-scan toggle period makes consecutive scans always disagree
    base = n_pulse;
    for (int i = 0; i < 7; i++) begin
      held[12] = ~held[12];
      wait_cyc(16);
    end
    check("bounce_no_pulse", n_pulse - base, 0);
    held[12] = 1'b1;
    wait_cyc(70);
    check("bounce_pulses", n_pulse - base, 1);
    check("bounce_code", last_code, 4'hA);
    held = '0;
    wait_cyc(70);

    // Multi-key: "1" then add "9"
    base = n_pulse;
    held[0] = 1'b1;
    wait_cyc(70);
    check("m1_pulses", n_pulse - base, 1);
    check("m1_code", last_code, 4'h1);
    held[10] = 1'b1;
    wait_cyc(70);
    check("m19_multi", kp.multi_key, 1'b1);
    check("m19_pulses", n_pulse - base, 1);
    held[0] = 1'b0;
    wait_cyc(70);
    check("m9_multi", kp.multi_key, 1'b0);
    check("m9_pressed", kp.key_pressed, 1'b1);
    check("m9_pulses", n_pulse - base, 1);
    held = '0;
    wait_cyc(70);
    check("mall_released", kp.key_pressed, 1'b0);
    held[15] = 1'b1;
    wait_cyc(70);
    check("mD_pulses", n_pulse - base, 2);
    check("mD_code", last_code, 4'hD);
    held = '0;
    wait_cyc(70);

    // Reset mid-scan with "0" (r3,c0) held
    held[3] = 1'b1;
    wait_cyc(70);
    check("r0_pressed", kp.key_pressed, 1'b1);
    for (int i = 0; i < 32 && kp.col != 4'b1011; i++) @(negedge clk);
    check("r0_reach_col2", kp.col, 4'b1011);
    rst = 1'b1;
    #1;
    check("r0_col_clear", kp.col, 4'b1110);
    check("r0_pressed_clear", kp.key_pressed, 1'b0);
    check("r0_code_clear", kp.key_code, 4'h0);
    @(negedge clk);
    rst  = 1'b0;
    base = n_pulse;
    wait_cyc(48);
    check("r0_pulses", n_pulse - base, 1);
    check("r0_code", last_code, 4'h0);
    held = '0;
    wait_cyc(70);

    // Simultaneous "F" (r3,c1) and "E" (r3,c2)
    base = n_pulse;
    held[7]  = 1'b1;
    held[11] = 1'b1;
    wait_cyc(70);
    check("fe_no_pulse", n_pulse - base, 0);
    check("fe_pressed", kp.key_pressed, 1'b1);
    check("fe_multi", kp.multi_key, 1'b1);
    held = '0;
    wait_cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
